// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one data-memory port between two requesters: port 0 (core
//   load/store path) and port 1 (debug/loader engine). One access at a time,
//   round-robin on ties, fixed memory occupancy of MEM_LAT cycles, and a
//   one-cycle ack pulse after each access.
//
// Ports
//   clock, reset            : clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN   : request handshake and fields of port N
//   gntN                    : port N owns the memory (ACCESS and ACK)
//   ackN                    : one-cycle completion pulse for port N
//   rdata                   : data of the last completed read
//   mem_en/mem_we           : memory enable / single write strobe
//   mem_addr/mem_wdata      : latched address / write data
//   mem_rdata               : combinational memory read data
//   busy/owner              : arbiter not idle / granted port index
module data_mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  // A latency of 0 behaves as 1; the counter is 4 bits wide (1..15).
  localparam int LAT = (MEM_LAT < 1) ? 1 : MEM_LAT;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t      state;
  logic        last_owner;
  logic        we_l;
  logic [3:0]  cnt;

  // Winner of an arbitration in IDLE: on a tie, the port that was not served
  // last; otherwise whichever port is requesting.
  logic pick;
  assign pick = (req0 && req1) ? ~last_owner : req1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      we_l       <= 1'b0;
      cnt        <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            // Fields are latched here so later input changes cannot disturb
            // the access in flight.
            owner     <= pick;
            we_l      <= pick ? we1 : we0;
            mem_addr  <= pick ? addr1 : addr0;
            mem_wdata <= pick ? wdata1 : wdata0;
            cnt       <= 4'(LAT - 1);
            gnt0      <= ~pick;
            gnt1      <= pick;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            // With a one-cycle access the first ACCESS cycle is also the last.
            mem_we    <= (LAT == 1) ? (pick ? we1 : we0) : 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt    <= cnt - 4'd1;
            // Raise the write strobe for the final ACCESS cycle only.
            mem_we <= (cnt == 4'd1) ? we_l : 1'b0;
          end else begin
            if (!we_l) begin
              rdata <= mem_rdata;
            end
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            ack0   <= ~owner;
            ack1   <= owner;
            state  <= ACK;
          end
        end
        ACK: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          gnt0       <= 1'b0;
          gnt1       <= 1'b0;
          busy       <= 1'b0;
          last_owner <= owner;
          state      <= IDLE;
        end
        default: begin
          state  <= IDLE;
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Directed bench for data_mem_arbiter. Three instances share clock and
//   reset: index 0 uses MEM_LAT=1, index 1 MEM_LAT=3, index 2 MEM_LAT=2.
//   Each instance has its own 256-word memory model.
module tb_data_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic [2:0]  req0 = '0, we0 = '0, req1 = '0, we1 = '0;
  logic [7:0]  addr0 [3];
  logic [7:0]  addr1 [3];
  logic [15:0] wdata0 [3];
  logic [15:0] wdata1 [3];
  logic [2:0]  gnt0, ack0, gnt1, ack1, mem_en, mem_we, busy, owner;
  logic [15:0] rdata [3];
  logic [7:0]  mem_addr [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];
  logic [15:0] mem [3][256];

  int checks = 0;
  int passed = 0;
  int excl_viol = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : gi
    data_mem_arbiter #(
      .ADDR_W (8),
      .DATA_W (16),
      .MEM_LAT(g == 0 ? 1 : (g == 1 ? 3 : 2))
    ) dut (
      .clock    (clock),
      .reset    (reset),
      .req0     (req0[g]),
      .we0      (we0[g]),
      .addr0    (addr0[g]),
      .wdata0   (wdata0[g]),
      .gnt0     (gnt0[g]),
      .ack0     (ack0[g]),
      .req1     (req1[g]),
      .we1      (we1[g]),
      .addr1    (addr1[g]),
      .wdata1   (wdata1[g]),
      .gnt1     (gnt1[g]),
      .ack1     (ack1[g]),
      .rdata    (rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g]),
      .owner    (owner[g])
    );

    assign mem_rdata[g] = mem[g][mem_addr[g]];

    always @(posedge clock) begin
      if (mem_en[g] && mem_we[g]) mem[g][mem_addr[g]] <= mem_wdata[g];
    end

    always @(negedge clock) begin
      if ((gnt0[g] && gnt1[g]) || (ack0[g] && ack1[g])) excl_viol++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, cnt1, n;
    bit got;
    for (int i = 0; i < 3; i++) begin
      addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 256; j++) mem[i][j] <= 16'(j);
    mem[0][8'h05] <= 16'h1234;
    mem[0][8'h06] <= 16'h5678;
    mem[1][8'h20] <= 16'h5555;
    mem[2][8'h44] <= 16'hCAFE;
    mem[2][8'h33] <= 16'h1111;

    // Reset state
    tick(); tick();
    chk("rst_gnt0", gnt0[0], 0);
    chk("rst_ack0", ack0[0], 0);
    chk("rst_mem_en", mem_en[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_rdata", rdata[0], 0);
    reset = 1'b0;

    // Test 1: MEM_LAT=1 read of 0x05
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'h05;
    tick(); // t+1
    chk("t1_gnt0_a", gnt0[0], 1);
    chk("t1_mem_en_a", mem_en[0], 1);
    chk("t1_mem_addr", mem_addr[0], 8'h05);
    chk("t1_mem_we_a", mem_we[0], 0);
    chk("t1_ack0_a", ack0[0], 0);
    chk("t1_owner", owner[0], 0);
    tick(); // t+2
    chk("t1_ack0_b", ack0[0], 1);
    chk("t1_gnt0_b", gnt0[0], 1);
    chk("t1_mem_en_b", mem_en[0], 0);
    chk("t1_mem_we_b", mem_we[0], 0);
    req0[0] = 1'b0;
    tick(); // t+3
    chk("t1_rdata", rdata[0], 16'h1234);
    chk("t1_ack0_c", ack0[0], 0);
    chk("t1_busy_c", busy[0], 0);

    // Test 2: simultaneous requests right after reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0[0] = 1'b1; addr0[0] = 8'h05;
    req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 8'h06;
    tick(); // t+1
    chk("t2_gnt0", gnt0[0], 1);
    chk("t2_gnt1_a", gnt1[0], 0);
    tick(); // t+2
    chk("t2_ack0", ack0[0], 1);
    req0[0] = 1'b0;
    tick(); // t+3 arbitration
    chk("t2_idle_gnt1", gnt1[0], 0);
    tick(); // t+4
    chk("t2_gnt1_b", gnt1[0], 1);
    chk("t2_owner", owner[0], 1);
    tick(); // t+5
    chk("t2_ack1", ack1[0], 1);
    req1[0] = 1'b0;
    tick();
    chk("t2_rdata", rdata[0], 16'h5678);

    // Test 3: MEM_LAT=3 write from port 1, then read back
    req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = 8'h10; wdata1[1] = 16'hBEEF;
    tick(); // t+1
    chk("t3_en1", mem_en[1], 1);
    chk("t3_addr1", mem_addr[1], 8'h10);
    chk("t3_we1", mem_we[1], 0);
    tick(); // t+2
    chk("t3_en2", mem_en[1], 1);
    chk("t3_we2", mem_we[1], 0);
    tick(); // t+3
    chk("t3_en3", mem_en[1], 1);
    chk("t3_we3", mem_we[1], 1);
    chk("t3_wdata", mem_wdata[1], 16'hBEEF);
    chk("t3_addr3", mem_addr[1], 8'h10);
    tick(); // t+4
    chk("t3_ack1", ack1[1], 1);
    chk("t3_we4", mem_we[1], 0);
    req1[1] = 1'b0;
    tick();
    chk("t3_rdata_kept", rdata[1], 0);
    chk("t3_mem", mem[1][8'h10], 16'hBEEF);
    req1[1] = 1'b1; we1[1] = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t3_rd_ack", ack1[1], 1);
    req1[1] = 1'b0;
    tick();
    chk("t3_readback", rdata[1], 16'hBEEF);

    // Test 4: fairness with both ports requesting continuously
    req0[0] = 1'b1; addr0[0] = 8'h05;
    req1[0] = 1'b1; addr1[0] = 8'h06;
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0; got = 1'b0;
      while (!got && n < 12) begin
        tick();
        n++;
        if (ack0[0] || ack1[0]) got = 1'b1;
      end
      chk("t4_ack_seen", 32'(got), 1);
      chk("t4_order", 32'(ack1[0]), 32'(k % 2));
      cnt0 += int'(ack0[0]);
      cnt1 += int'(ack1[0]);
    end
    chk("t4_cnt0", cnt0, 3);
    chk("t4_cnt1", cnt1, 3);
    req0[0] = 1'b0; req1[0] = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t4_idle", busy[0], 0);

    // Test 5: MEM_LAT=3 write aborted by reset
    req0[1] = 1'b1; we0[1] = 1'b1; addr0[1] = 8'h20; wdata0[1] = 16'hAAAA;
    tick(); // t+1
    chk("t5_we1", mem_we[1], 0);
    tick(); // t+2
    chk("t5_we2", mem_we[1], 0);
    reset = 1'b1; req0[1] = 1'b0;
    tick(); // t+3
    chk("t5_gnt0", gnt0[1], 0);
    chk("t5_gnt1", gnt1[1], 0);
    chk("t5_ack0", ack0[1], 0);
    chk("t5_ack1", ack1[1], 0);
    chk("t5_en", mem_en[1], 0);
    chk("t5_we", mem_we[1], 0);
    chk("t5_addr", mem_addr[1], 0);
    chk("t5_wdata", mem_wdata[1], 0);
    chk("t5_busy", busy[1], 0);
    chk("t5_owner", owner[1], 0);
    chk("t5_rdata", rdata[1], 0);
    reset = 1'b0;
    tick(); tick();
    chk("t5_no_ack", ack0[1], 0);
    chk("t5_mem", mem[1][8'h20], 16'h5555);

    // Test 6: MEM_LAT=2, request dropped and address changed mid-access
    req0[2] = 1'b1; we0[2] = 1'b0; addr0[2] = 8'h44;
    tick(); // t+1
    req0[2] = 1'b0; addr0[2] = 8'h33;
    chk("t6_addr1", mem_addr[2], 8'h44);
    tick(); // t+2
    chk("t6_addr2", mem_addr[2], 8'h44);
    chk("t6_en2", mem_en[2], 1);
    tick(); // t+3
    chk("t6_ack0", ack0[2], 1);
    tick(); // t+4
    chk("t6_rdata", rdata[2], 16'hCAFE);
    chk("t6_busy", busy[2], 0);

    chk("exclusive_gnt_ack", excl_viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
